// File: rtl/id_ex_stage_pkg.sv
// Shared types and constants for the ID/EX pipeline register slice.
// Latency: n/a (types, constants and decode helpers only).
// Backpressure: n/a.
package id_ex_stage_pkg;

    // Major opcodes for the instruction classes the decoder emits.
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // ALUOp encodings carried in the alu_op field of the control bundle.
    localparam logic [1:0] ALU_OP_ADD    = 2'b00;
    localparam logic [1:0] ALU_OP_SUB    = 2'b01;
    localparam logic [1:0] ALU_OP_R_TYPE = 2'b10;

    // Bit offsets of each field inside the flat 11-bit control bundle.
    localparam int CTRL_W           = 11;
    localparam int CTRL_ALU_OP_LSB  = 9;
    localparam int CTRL_REG_DST     = 8;
    localparam int CTRL_BRANCH      = 7;
    localparam int CTRL_MEM_READ    = 6;
    localparam int CTRL_MEM_2_REG   = 5;
    localparam int CTRL_MEM_WRITE   = 4;
    localparam int CTRL_ALU_SRC     = 3;
    localparam int CTRL_REG_WRITE   = 2;
    localparam int CTRL_JUMP        = 1;
    localparam int CTRL_PAD         = 0;

    // Decoded control bundle, MSB first, matching the offsets above.
    typedef struct packed {
        logic [1:0] alu_op;
        logic       reg_dst;
        logic       branch;
        logic       mem_read;
        logic       mem_2_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic       jump;
        logic       pad;
    } ctrl_t;

    // True when the bundle describes a load (result arrives a stage late).
    function automatic logic ctrl_is_load(input ctrl_t c);
        return c.mem_read;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-side inputs and EX-side registered copies of one instruction slot.
// Latency: n/a (wiring only).
// Backpressure: stall travels back to the ID side on the same bundle.
interface id_ex_stage_if
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int REG_IDX_W = 5
);
    logic                 id_valid;
    ctrl_t                id_ctrl;
    logic [DATA_W-1:0]    id_rs1_data;
    logic [DATA_W-1:0]    id_rs2_data;
    logic [DATA_W-1:0]    id_imm;
    logic [DATA_W-1:0]    id_pc;
    logic [REG_IDX_W-1:0] id_rs1;
    logic [REG_IDX_W-1:0] id_rs2;
    logic [REG_IDX_W-1:0] id_rd;
    logic [3:0]           id_func;

    logic                 ex_valid;
    ctrl_t                ex_ctrl;
    logic [DATA_W-1:0]    ex_rs1_data;
    logic [DATA_W-1:0]    ex_rs2_data;
    logic [DATA_W-1:0]    ex_imm;
    logic [DATA_W-1:0]    ex_pc;
    logic [REG_IDX_W-1:0] ex_rs1;
    logic [REG_IDX_W-1:0] ex_rs2;
    logic [REG_IDX_W-1:0] ex_rd;
    logic [3:0]           ex_func;

    logic                 stall;

    // Decode side: presents the ID instruction, observes EX and stall.
    modport master (
        output id_valid, id_ctrl, id_rs1_data, id_rs2_data, id_imm, id_pc,
               id_rs1, id_rs2, id_rd, id_func,
        input  ex_valid, ex_ctrl, ex_rs1_data, ex_rs2_data, ex_imm, ex_pc,
               ex_rs1, ex_rs2, ex_rd, ex_func, stall
    );

    // Pipeline register: samples ID, drives EX and the stall request.
    modport slave (
        input  id_valid, id_ctrl, id_rs1_data, id_rs2_data, id_imm, id_pc,
               id_rs1, id_rs2, id_rd, id_func,
        output ex_valid, ex_ctrl, ex_rs1_data, ex_rs2_data, ex_imm, ex_pc,
               ex_rs1, ex_rs2, ex_rd, ex_func, stall
    );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detector between the EX-stage load and the ID-stage consumer.
// Latency: purely combinational, zero cycles.
// Backpressure: none; result feeds the stall request.
module hazard_detect #(
    parameter int REG_IDX_W = 5
) (
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 ex_valid,
    input  logic                 ex_mem_read,
    input  logic [REG_IDX_W-1:0] ex_rd,
    output logic                 hazard
);

    logic rd_nonzero;
    logic rd_match;

    // x0 never carries a real result, so a load into it cannot cause a hazard.
    always_comb begin
        rd_nonzero = (ex_rd != '0);
        rd_match   = (ex_rd == id_rs1) || (ex_rd == id_rs2);
        hazard     = id_valid && ex_valid && ex_mem_read && rd_nonzero && rd_match;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and flush kill.
// Latency: one cycle from id_* to ex_*; stall is combinational from state.
// Backpressure: stall freezes PC and IF/ID; en=0 freezes everything here.
// Optional perf counters (stall_cnt, flush_cnt) built when ID_EX_PERF_CNT_EN is defined.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int REG_IDX_W = 5,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             en,
    input  logic             flush,
    id_ex_stage_if.slave     bus
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    logic                 hazard;
    logic                 stall;

    logic                 valid_q;
    ctrl_t                ctrl_q;
    logic [DATA_W-1:0]    rs1_data_q;
    logic [DATA_W-1:0]    rs2_data_q;
    logic [DATA_W-1:0]    imm_q;
    logic [DATA_W-1:0]    pc_q;
    logic [REG_IDX_W-1:0] rs1_q;
    logic [REG_IDX_W-1:0] rs2_q;
    logic [REG_IDX_W-1:0] rd_q;
    logic [3:0]           func_q;

    hazard_detect #(
        .REG_IDX_W (REG_IDX_W)
    ) u_hazard_detect (
        .id_valid    (bus.id_valid),
        .id_rs1      (bus.id_rs1),
        .id_rs2      (bus.id_rs2),
        .ex_valid    (valid_q),
        .ex_mem_read (ctrl_is_load(ctrl_q)),
        .ex_rd       (rd_q),
        .hazard      (hazard)
    );

    // A taken branch kills the consumer anyway, so it must not also freeze the front end.
    assign stall = hazard && !flush;

    // Flush and hazard both inject a bubble; data fields keep their old value
    // since ctrl=0 already makes the slot inert downstream.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            valid_q    <= 1'b0;
            ctrl_q     <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            pc_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            func_q     <= '0;
        end else if (en) begin
            if (flush || hazard) begin
                valid_q <= 1'b0;
                ctrl_q  <= '0;
            end else begin
                valid_q    <= bus.id_valid;
                ctrl_q     <= bus.id_valid ? bus.id_ctrl : '0;
                rs1_data_q <= bus.id_rs1_data;
                rs2_data_q <= bus.id_rs2_data;
                imm_q      <= bus.id_imm;
                pc_q       <= bus.id_pc;
                rs1_q      <= bus.id_rs1;
                rs2_q      <= bus.id_rs2;
                rd_q       <= bus.id_rd;
                func_q     <= bus.id_func;
            end
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Event counters; wrap naturally at 2^CNT_W. Only real kills count as flushes.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (en) begin
            if (stall) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (flush && bus.id_valid) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

    assign bus.stall       = stall;
    assign bus.ex_valid    = valid_q;
    assign bus.ex_ctrl     = ctrl_q;
    assign bus.ex_rs1_data = rs1_data_q;
    assign bus.ex_rs2_data = rs2_data_q;
    assign bus.ex_imm      = imm_q;
    assign bus.ex_pc       = pc_q;
    assign bus.ex_rs1      = rs1_q;
    assign bus.ex_rs2      = rs2_q;
    assign bus.ex_rd       = rd_q;
    assign bus.ex_func     = func_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage against a slot-level reference model.
// Latency: expects one cycle ID->EX, combinational stall.
// Backpressure: models stall retention of the ID instruction by replaying it.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

`ifdef ID_EX_PERF_CNT_EN
    localparam int CNT_W = 4;
`else
    localparam int CNT_W = 32;
`endif

    typedef struct {
        logic        valid;
        ctrl_t       ctrl;
        logic [63:0] rs1d;
        logic [63:0] rs2d;
        logic [63:0] imm;
        logic [63:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  func;
    } instr_t;

    logic clk;
    logic arst_n;
    logic en;
    logic flush;

    id_ex_stage_if #(.DATA_W(64), .REG_IDX_W(5)) bus ();

`ifdef ID_EX_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
`endif

    id_ex_stage #(
        .DATA_W    (64),
        .REG_IDX_W (5),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .en        (en),
        .flush     (flush),
        .bus       (bus)
`ifdef ID_EX_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: what instruction sits in the EX slot, plus event tallies.
    instr_t m_ex;
    int     m_stalls = 0;
    int     m_flushes = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic instr_t bubble_of(input instr_t keep);
        instr_t r;
        r       = keep;
        r.valid = 1'b0;
        r.ctrl  = '0;
        return r;
    endfunction

    function automatic instr_t zero_instr();
        instr_t r;
        r.valid = 1'b0; r.ctrl = '0;
        r.rs1d = '0; r.rs2d = '0; r.imm = '0; r.pc = '0;
        r.rs1 = '0; r.rs2 = '0; r.rd = '0; r.func = '0;
        return r;
    endfunction

    function automatic instr_t rand_instr();
        instr_t      r;
        logic [10:0] c;
        c      = 11'($urandom_range(0, 2047));
        r.valid = ($urandom_range(0, 3) != 0);
        r.ctrl  = c;
        r.rs1d  = {$urandom, $urandom};
        r.rs2d  = {$urandom, $urandom};
        r.imm   = {$urandom, $urandom};
        r.pc    = {$urandom, $urandom};
        r.rs1   = 5'($urandom_range(0, 3));
        r.rs2   = 5'($urandom_range(0, 3));
        r.rd    = 5'($urandom_range(0, 3));
        r.func  = 4'($urandom_range(0, 15));
        return r;
    endfunction

    function automatic instr_t mk(input logic v, input logic is_load, input int rs1,
                                  input int rs2, input int rd, input logic [63:0] pc);
        instr_t r;
        r           = zero_instr();
        r.valid     = v;
        r.ctrl.mem_read  = is_load;
        r.ctrl.mem_2_reg = is_load;
        r.ctrl.reg_write = 1'b1;
        r.ctrl.alu_src   = is_load;
        r.ctrl.alu_op    = is_load ? ALU_OP_ADD : ALU_OP_R_TYPE;
        r.rs1  = 5'(rs1);
        r.rs2  = 5'(rs2);
        r.rd   = 5'(rd);
        r.pc   = pc;
        r.imm  = pc ^ 64'h55;
        r.rs1d = pc + 64'd1;
        r.rs2d = pc + 64'd2;
        r.func = 4'(rd);
        return r;
    endfunction

    task automatic apply(input instr_t in);
        bus.id_valid    = in.valid;
        bus.id_ctrl     = in.ctrl;
        bus.id_rs1_data = in.rs1d;
        bus.id_rs2_data = in.rs2d;
        bus.id_imm      = in.imm;
        bus.id_pc       = in.pc;
        bus.id_rs1      = in.rs1;
        bus.id_rs2      = in.rs2;
        bus.id_rd       = in.rd;
        bus.id_func     = in.func;
    endtask

    task automatic check_ex(input string tag);
        chk({tag, ".valid"}, {63'b0, bus.ex_valid}, {63'b0, m_ex.valid});
        chk({tag, ".ctrl"},  {53'b0, bus.ex_ctrl},  {53'b0, m_ex.ctrl});
        chk({tag, ".rs1d"},  bus.ex_rs1_data, m_ex.rs1d);
        chk({tag, ".rs2d"},  bus.ex_rs2_data, m_ex.rs2d);
        chk({tag, ".imm"},   bus.ex_imm, m_ex.imm);
        chk({tag, ".pc"},    bus.ex_pc, m_ex.pc);
        chk({tag, ".rs1"},   {59'b0, bus.ex_rs1}, {59'b0, m_ex.rs1});
        chk({tag, ".rs2"},   {59'b0, bus.ex_rs2}, {59'b0, m_ex.rs2});
        chk({tag, ".rd"},    {59'b0, bus.ex_rd}, {59'b0, m_ex.rd});
        chk({tag, ".func"},  {60'b0, bus.ex_func}, {60'b0, m_ex.func});
`ifdef ID_EX_PERF_CNT_EN
        chk({tag, ".stall_cnt"}, {{(64-CNT_W){1'b0}}, stall_cnt}, 64'(m_stalls % (1 << CNT_W)));
        chk({tag, ".flush_cnt"}, {{(64-CNT_W){1'b0}}, flush_cnt}, 64'(m_flushes % (1 << CNT_W)));
`endif
    endtask

    // One clock: drive at negedge, check stall mid-cycle, advance model, check EX.
    // Returns the stall the model expected, so callers can replay a stalled instruction.
    task automatic cycle(input instr_t in, input logic f, input logic e, output logic exp_stall);
        logic load_use;
        @(negedge clk);
        apply(in);
        flush = f;
        en    = e;
        #1;
        // Consumer in ID needs a register that the load in EX has not produced yet.
        load_use  = in.valid && m_ex.valid && m_ex.ctrl.mem_read && (m_ex.rd != 5'd0)
                    && ((m_ex.rd == in.rs1) || (m_ex.rd == in.rs2));
        exp_stall = load_use && !f;
        chk("stall", {63'b0, bus.stall}, {63'b0, exp_stall});
        @(posedge clk);
        #1;
        if (e) begin
            if (exp_stall) m_stalls++;
            if (f && in.valid) m_flushes++;
            if (f || load_use) begin
                m_ex = bubble_of(m_ex);
            end else begin
                m_ex = in;
                if (!in.valid) m_ex.ctrl = '0;
            end
        end
        check_ex("ex");
    endtask

    instr_t cur;
    instr_t snap;
    logic   st;

    initial begin
        m_ex   = zero_instr();
        en     = 1'b1;
        flush  = 1'b0;
        cur    = rand_instr();
        cur.valid = 1'b1;
        cur.ctrl  = 11'h7FF;
        apply(cur);
        arst_n = 1'b0;
        #1;
        // Reset must clear immediately, before any clock edge, despite live ID inputs.
        chk("rst_valid", {63'b0, bus.ex_valid}, 64'd0);
        chk("rst_ctrl",  {53'b0, bus.ex_ctrl}, 64'd0);
        chk("rst_stall", {63'b0, bus.stall}, 64'd0);
        check_ex("rst");
        repeat (2) @(posedge clk);
        #1 arst_n = 1'b1;

        // Load x5 then add x6,x5,x7: one stall, one bubble, add lands two cycles after load.
        cycle(mk(1'b0, 1'b0, 0, 0, 0, 64'h0), 1'b0, 1'b1, st);
        cycle(mk(1'b1, 1'b1, 1, 0, 5, 64'h100), 1'b0, 1'b1, st);
        chk("ld_in_ex", {59'b0, bus.ex_rd}, 64'd5);
        cycle(mk(1'b1, 1'b0, 5, 7, 6, 64'h104), 1'b0, 1'b1, st);
        chk("use_stalled", {63'b0, st}, 64'd1);
        chk("bubble", {63'b0, bus.ex_valid}, 64'd0);
        cycle(mk(1'b1, 1'b0, 5, 7, 6, 64'h104), 1'b0, 1'b1, st);
        chk("one_stall_only", {63'b0, st}, 64'd0);
        chk("add_in_ex", bus.ex_pc, 64'h104);

        // Load into x0 followed by a use of x0: no stall, no bubble.
        cycle(mk(1'b1, 1'b1, 1, 0, 0, 64'h200), 1'b0, 1'b1, st);
        cycle(mk(1'b1, 1'b0, 0, 0, 3, 64'h204), 1'b0, 1'b1, st);
        chk("x0_no_stall", {63'b0, st}, 64'd0);
        chk("x0_no_bubble", {63'b0, bus.ex_valid}, 64'd1);

        // Flush coinciding with a load-use hazard: flush wins, single bubble.
        cycle(mk(1'b1, 1'b1, 1, 0, 5, 64'h300), 1'b0, 1'b1, st);
        cycle(mk(1'b1, 1'b0, 5, 0, 6, 64'h304), 1'b1, 1'b1, st);
        chk("flush_hz_stall", {63'b0, st}, 64'd0);
        chk("flush_hz_valid", {63'b0, bus.ex_valid}, 64'd0);

        // Enable low for three cycles with changing ID inputs holds EX.
        cycle(mk(1'b1, 1'b0, 1, 2, 3, 64'h400), 1'b0, 1'b1, st);
        snap = m_ex;
        for (int i = 0; i < 3; i++) begin
            cycle(rand_instr(), 1'b0, 1'b0, st);
        end
        chk("en_hold_pc", bus.ex_pc, 64'h400);
        cycle(mk(1'b1, 1'b0, 1, 2, 9, 64'h500), 1'b0, 1'b1, st);
        chk("en_resume_pc", bus.ex_pc, 64'h500);

        // Sixteen separate load-use stalls (wraps a 4-bit stall counter).
        for (int i = 0; i < 16; i++) begin
            cycle(mk(1'b1, 1'b1, 0, 0, 4, 64'(i * 8)), 1'b0, 1'b1, st);
            cycle(mk(1'b1, 1'b0, 1, 4, 2, 64'(i * 8 + 4)), 1'b0, 1'b1, st);
        end
        chk("stall_total", 64'(m_stalls), 64'd17);
`ifdef ID_EX_PERF_CNT_EN
        chk("stall_cnt_wrap", {{(64-CNT_W){1'b0}}, stall_cnt}, 64'd1);
`endif

        // Randomized traffic; a stalled instruction is replayed as IF/ID would hold it.
        cur = rand_instr();
        for (int i = 0; i < 400; i++) begin
            cycle(cur, ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) != 0), st);
            if (!st || !en) cur = rand_instr();
            if (i == 200) begin
                // Asynchronous reset in mid-cycle, then released between edges.
                @(negedge clk);
                #2 arst_n = 1'b0;
                #1;
                m_ex      = zero_instr();
                m_stalls  = 0;
                m_flushes = 0;
                chk("mid_rst_valid", {63'b0, bus.ex_valid}, 64'd0);
                chk("mid_rst_stall", {63'b0, bus.stall}, 64'd0);
                check_ex("mid_rst");
                @(posedge clk);
                #1 arst_n = 1'b1;
                cur = rand_instr();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: DATA_W, default 64, datapath width of operands, immediate and PC.
REQ-002 Parameter: REG_IDX_W, default 5, register index width.
REQ-003 Parameter: CNT_W, default 32, width of performance counters.
REQ-004 clk  in  1  single clock, all state rising-edge.
REQ-005 arst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 en  in  1  global pipeline enable; 0 holds all state.
REQ-007 flush  in  1  branch/jump taken in EX; kill the ID-stage instruction.
REQ-008 id_valid  in  1  ID stage holds a real instruction.
REQ-009 id_ctrl  in  11  decoded control bundle: alu_op[1:0], reg_dst, branch, mem_read, mem_2_reg, mem_write, alu_src, reg_write, jump, pad.
REQ-010 id_rs1_data, id_rs2_data, id_imm, id_pc  in  DATA_W each  ID-stage operands.
REQ-011 id_rs1, id_rs2, id_rd  in  REG_IDX_W each  register indices.
REQ-012 id_func  in  4  {instr[30], instr[14:12]} for ALU control.
REQ-013 ex_valid, ex_ctrl, ex_rs1_data, ex_rs2_data, ex_imm, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_func  out  widths as inputs  registered EX-side copies.
REQ-014 stall  out  1  load-use hazard; freezes PC and IF/ID.
REQ-015 stall_cnt, flush_cnt  out  CNT_W each  performance counters (present only per REQ-031).

Function
REQ-016 hazard = id_valid & ex_valid & ex_ctrl.mem_read & (ex_rd != 0) & (ex_rd == id_rs1 | ex_rd == id_rs2); combinational.
REQ-017 stall SHALL equal hazard & ~flush; zero-cycle path, no register.
REQ-018 Update priority at each clk edge with en=1: flush > hazard > load.
REQ-019 flush: ex_valid<=0, ex_ctrl<=0; data fields don't-care but held.
REQ-020 hazard (no flush): bubble -- ex_valid<=0, ex_ctrl<=0; ID instruction retained upstream by stall and accepted next cycle.
REQ-021 load: all ex_* <= id_*, ex_valid<=id_valid; ex_ctrl<=0 when id_valid=0.
REQ-022 en=0: every register holds, stall still computed from current state; counters hold.
REQ-023 Latency: one cycle from id_* to ex_* when loaded.
REQ-024 Invariant: ex_valid=0 implies ex_ctrl=0 (no reg_write/mem_write/branch/jump leaks from bubbles).
REQ-025 Back-to-back hazard SHALL not occur: after a bubble ex_valid=0, so stall deasserts next cycle (max one stall cycle per load-use).
REQ-026 Simultaneous flush and hazard: flush wins, stall=0, single bubble.

Reset
REQ-027 arst_n low SHALL immediately clear ex_valid, ex_ctrl, all ex_* data/index fields, and counters to 0.
REQ-028 stall SHALL read 0 during reset (ex_valid=0).
REQ-029 Reset deassertion mid-stream: first edge with en=1 loads id_*; no phantom instruction.

Configuration
REQ-030 Macro ID_EX_PERF_CNT_EN selects performance counters.
REQ-031 Defined: stall_cnt increments on every en=1 edge with stall=1; flush_cnt on every en=1 edge with flush=1 & id_valid=1; both wrap at 2^CNT_W-1 -> 0. Undefined: ports and counters absent.

Structure
REQ-032 Shared package holds opcode constants, ALUOp encodings (ADD=00, SUB=01, R_TYPE=10) and the ctrl-bundle field offsets.
REQ-033 Sub-module hazard_detect implements REQ-016 combinationally; registers stay in id_ex_stage.

Verification
REQ-034 Reset: arst_n=0 with id_valid=1, id_ctrl=all ones -> ex_valid=0, ex_ctrl=0, stall=0 immediately, no clock.
REQ-035 Pass-through: ld x5 (mem_read, rd=5) then add x6,x5,x7 (rs1=5) -> stall=1 one cycle, one bubble, add appears in EX two cycles after load.
REQ-036 x0 load: load rd=0 followed by use of x0 -> stall=0, no bubble.
REQ-037 Flush+hazard same cycle: flush=1 with load-use condition -> stall=0, ex_valid=0 next cycle, flush_cnt+1, stall_cnt unchanged.
REQ-038 Enable hold: en=0 for 3 cycles with changing id_* -> ex_* constant; en=1 -> latest id_* loaded.
REQ-039 Counter wrap (ID_EX_PERF_CNT_EN, CNT_W=4): 16 stalls -> stall_cnt returns to 0.
